// File: rtl/neuron_core_pkg.sv
// Shared encodings and arithmetic helpers for the LIF neuron core.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package neuron_core_pkg;

  // Operation encodings carried on EVT_TYPE
  localparam logic [1:0] EVT_SYN  = 2'b00;
  localparam logic [1:0] EVT_LEAK = 2'b01;
  localparam logic [1:0] EVT_CFG  = 2'b10;
  localparam logic [1:0] EVT_RD   = 2'b11;

  // State word layout {dis, leak[W], thr[W], v[W]}; v always starts at bit 0
  function automatic int thr_lsb(input int w);
    return w;
  endfunction

  function automatic int leak_lsb(input int w);
    return 2 * w;
  endfunction

  function automatic int dis_bit(input int w);
    return 3 * w;
  endfunction

  // a + b clamped to the largest unsigned w-bit value
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) return lim[31:0];
    return sum[31:0];
  endfunction

  // a - b clamped at zero
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/sram_sdp_wrapper.sv
// Simple dual-port state memory: one synchronous read port, one write port.
// Latency: read data valid one cycle after re; same-address read-during-write returns old data.
// Backpressure: none, both ports accept every cycle.
module sram_sdp_wrapper #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 25
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // Behavioral array; q captures the pre-write contents on address collisions
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/neuron_core_pipelined.sv
// LIF neuron array with a 2-stage read-modify-write pipeline, forwarding and a 2-entry spike buffer.
// Latency: op accepted in cycle t writes back at the end of t+1; spike/read result visible in t+2.
// Backpressure: EVT_READY drops while buffered plus in-flight spikes could exceed 2; SPK_READY pops.
module neuron_core_pipelined #(
  parameter int N  = 256,
  parameter int M  = 8,
  parameter int W  = 8,
  parameter int WW = 3
) (
  input  logic             CLK,
  input  logic             RSTN_syncn,
  input  logic             EVT_VALID,
  output logic             EVT_READY,
  input  logic [1:0]       EVT_TYPE,
  input  logic [M-1:0]     EVT_ADDR,
  input  logic [WW-1:0]    EVT_WEIGHT,
  input  logic             EVT_SIGN,
  input  logic [3*W:0]     CFG_WDATA,
  output logic             RD_VALID,
  output logic [3*W:0]     RD_DATA,
  output logic             SPK_VALID,
  output logic [M-1:0]     SPK_ADDR,
  input  logic             SPK_READY,
  output logic             INIT_DONE
);
  import neuron_core_pkg::*;

  localparam int SW   = 3 * W + 1;
  localparam int THR  = thr_lsb(W);
  localparam int LEAK = leak_lsb(W);
  localparam int DIS  = dis_bit(W);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [M-1:0]  sweep_cnt;

  logic          s1_valid;
  logic [1:0]    s1_type;
  logic [M-1:0]  s1_addr;
  logic [WW-1:0] s1_weight;
  logic          s1_sign;
  logic [SW-1:0] s1_cfg;

  logic          fwd_vld;
  logic [M-1:0]  fwd_addr;
  logic [SW-1:0] fwd_dat;

  logic [SW-1:0] mem_q;
  logic [SW-1:0] cur;
  logic [SW-1:0] wr_dat;
  logic          wr_en;
  logic          spk_push;
  logic          rd_hit;
  logic [W-1:0]  v_exc, v_inh, v_lk;

  logic [1:0]    spk_count;
  logic [M-1:0]  spk_q0, spk_q1;
  logic          spk_pop;
  logic          accept;

  logic          mem_we;
  logic [M-1:0]  mem_waddr;
  logic [SW-1:0] mem_wdat;

  assign INIT_DONE = (state == ST_RUN);
  // At most two spikes may ever be buffered-or-in-flight, so the 2-entry buffer cannot overflow
  assign EVT_READY = INIT_DONE && (({1'b0, spk_count} + {2'b0, s1_valid}) <= 3'd1);
  assign accept    = EVT_VALID && EVT_READY;
  assign SPK_VALID = (spk_count != 2'd0);
  assign SPK_ADDR  = spk_q0;
  assign spk_pop   = SPK_VALID && SPK_READY;

  // Sweep writes zeros in INIT; S1 writes are suppressed during reset so an in-flight op is dropped
  assign mem_we    = RSTN_syncn && ((state == ST_INIT) || wr_en);
  assign mem_waddr = (state == ST_INIT) ? sweep_cnt : s1_addr;
  assign mem_wdat  = (state == ST_INIT) ? '0 : wr_dat;

  sram_sdp_wrapper #(.DEPTH(N), .AW(M), .DW(SW)) u_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdat),
    .re    (accept),
    .raddr (EVT_ADDR),
    .q     (mem_q)
  );

  // S1 compute: pick forwarded or stored word, apply the op, decide write/spike/read
  always_comb begin
    cur      = (fwd_vld && (fwd_addr == s1_addr)) ? fwd_dat : mem_q;
    v_exc    = W'(sat_add(32'(cur[W-1:0]), 32'(s1_weight), W));
    v_inh    = W'(sat_sub(32'(cur[W-1:0]), 32'(s1_weight)));
    v_lk     = W'(sat_sub(32'(cur[W-1:0]), 32'(cur[LEAK +: W])));
    wr_en    = 1'b0;
    wr_dat   = cur;
    spk_push = 1'b0;
    rd_hit   = 1'b0;
    if (s1_valid) begin
      case (s1_type)
        EVT_SYN: begin
          if (!cur[DIS]) begin
            wr_en = 1'b1;
            if (s1_sign) begin
              wr_dat[W-1:0] = v_inh;
            end else if (v_exc >= cur[THR +: W]) begin
              wr_dat[W-1:0] = '0;
              spk_push      = 1'b1;
            end else begin
              wr_dat[W-1:0] = v_exc;
            end
          end
        end
        EVT_LEAK: begin
          if (!cur[DIS]) begin
            wr_en         = 1'b1;
            wr_dat[W-1:0] = v_lk;
          end
        end
        EVT_CFG: begin
          wr_en  = 1'b1;
          wr_dat = s1_cfg;
        end
        default: rd_hit = 1'b1;
      endcase
    end
  end

  // INIT/RUN control with the clear-sweep address counter
  always_ff @(posedge CLK) begin
    if (!RSTN_syncn) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == M'(N - 1)) state <= ST_RUN;
    end
  end

  // S0 -> S1 op register
  always_ff @(posedge CLK) begin
    if (!RSTN_syncn) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_type   <= EVT_TYPE;
        s1_addr   <= EVT_ADDR;
        s1_weight <= EVT_WEIGHT;
        s1_sign   <= EVT_SIGN;
        s1_cfg    <= CFG_WDATA;
      end
    end
  end

  // Remember last cycle's write so the next op bypasses the stale memory read
  always_ff @(posedge CLK) begin
    if (!RSTN_syncn) begin
      fwd_vld <= 1'b0;
    end else begin
      fwd_vld  <= wr_en;
      fwd_addr <= s1_addr;
      fwd_dat  <= wr_dat;
    end
  end

  // Read response register
  always_ff @(posedge CLK) begin
    if (!RSTN_syncn) begin
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= rd_hit;
      if (rd_hit) RD_DATA <= cur;
    end
  end

  // 2-entry shift-register spike buffer; spk_q0 is the head
  always_ff @(posedge CLK) begin
    if (!RSTN_syncn) begin
      spk_count <= 2'd0;
      spk_q0    <= '0;
      spk_q1    <= '0;
    end else begin
      case ({spk_push, spk_pop})
        2'b10: begin
          if (spk_count == 2'd0) spk_q0 <= s1_addr;
          else                   spk_q1 <= s1_addr;
          spk_count <= spk_count + 2'd1;
        end
        2'b01: begin
          spk_q0    <= spk_q1;
          spk_count <= spk_count - 2'd1;
        end
        2'b11: begin
          if (spk_count == 2'd1) begin
            spk_q0 <= s1_addr;
          end else begin
            spk_q0 <= spk_q1;
            spk_q1 <= s1_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
